// File: rtl/double_to_sig16b_serial.sv
// Serial IEEE-754 binary64 to signed 16-bit converter with round-half-to-even.
// One mantissa bit is shifted out per clock, so latency tracks the exponent.
module double_to_sig16b_serial (
    input  logic        clk_operation,
    input  logic        rst,
    input  logic        enable,
    input  logic [63:0] double,
    output logic [15:0] sig16b,
    output logic        ready,
    output logic        busy,
    output logic        overflow,
    output logic        invalid
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        SHIFT,
        ROUND,
        DONE
    } state_t;

    state_t state, state_next;

    logic [63:0] operand;
    logic [52:0] mant;
    logic [5:0]  cnt;
    logic        guard;
    logic        sticky;
    logic        force_ovf;
    logic        force_inv;

    // Field split and classification of the captured operand
    logic        op_sign;
    logic [10:0] op_exp;
    logic [51:0] op_frac;
    logic        is_nan;
    logic        is_small;
    logic        is_big;
    logic        is_min;
    logic        is_special;
    logic [5:0]  shift_cnt;

    assign op_sign  = operand[63];
    assign op_exp   = operand[62:52];
    assign op_frac  = operand[51:0];
    assign is_nan   = (op_exp == 11'h7FF) && (op_frac != 52'd0);
    assign is_small = (op_exp <= 11'd1021);
    assign is_big   = (op_exp >= 11'd1038);
    assign is_min   = op_sign && (op_exp == 11'd1038) && (op_frac == 52'd0);
    assign is_special = is_nan || is_small || is_big;
    // n = 52 - (exp - 1023); only evaluated for exp in 1022..1037, so n is 38..53
    assign shift_cnt = 6'(11'd1075 - op_exp);

    // Rounding and final result selection
    logic        round_up;
    logic [16:0] q;
    logic [15:0] res_sig;
    logic        res_ovf;
    logic        res_inv;

    assign round_up = guard & (sticky | mant[0]);
    assign q        = {1'b0, mant[15:0]} + {16'd0, round_up};

    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/case leaves it unassigned, which would infer a latch.
    always_comb begin
        res_sig = 16'h0000;
        res_ovf = 1'b0;
        res_inv = 1'b0;
        if (force_inv) begin
            res_inv = 1'b1;
        end else if (force_ovf) begin
            res_sig = op_sign ? 16'h8000 : 16'h7FFF;
            res_ovf = 1'b1;
        end else if (!op_sign && (q >= 17'd32768)) begin
            res_sig = 16'h7FFF;
            res_ovf = 1'b1;
        end else if (op_sign) begin
            // -32768 falls out of the 16-bit negate naturally as 0x8000
            res_sig = 16'd0 - q[15:0];
        end else begin
            res_sig = q[15:0];
        end
    end

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the statements are written in.
    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = DECODE;
            DECODE:  state_next = is_special ? ROUND : SHIFT;
            SHIFT:   if (cnt == 6'd1) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk_operation or posedge rst) begin
        if (rst) begin
            operand   <= 64'd0;
            mant      <= 53'd0;
            cnt       <= 6'd0;
            guard     <= 1'b0;
            sticky    <= 1'b0;
            force_ovf <= 1'b0;
            force_inv <= 1'b0;
            sig16b    <= 16'h0000;
            overflow  <= 1'b0;
            invalid   <= 1'b0;
            ready     <= 1'b0;
        end else begin
            ready <= (state == ROUND);
            case (state)
                IDLE: begin
                    if (enable) operand <= double;
                end
                DECODE: begin
                    guard     <= 1'b0;
                    sticky    <= 1'b0;
                    force_inv <= is_nan;
                    force_ovf <= is_big && !is_min && !is_nan;
                    if (is_min) begin
                        mant <= 53'd32768;
                        cnt  <= 6'd0;
                    end else if (is_special) begin
                        mant <= 53'd0;
                        cnt  <= 6'd0;
                    end else begin
                        mant <= {1'b1, op_frac};
                        cnt  <= shift_cnt;
                    end
                end
                SHIFT: begin
                    mant   <= mant >> 1;
                    guard  <= mant[0];
                    sticky <= sticky | guard;
                    cnt    <= cnt - 6'd1;
                end
                ROUND: begin
                    sig16b   <= res_sig;
                    overflow <= res_ovf;
                    invalid  <= res_inv;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_double_to_sig16b_serial.sv
// Directed self-checking bench for double_to_sig16b_serial: latency, rounding,
// saturation, NaN, reset abort, enable-while-busy and a random round-trip.
module tb_double_to_sig16b_serial;

    logic        clk_operation = 1'b0;
    logic        rst;
    logic        enable;
    logic [63:0] double;
    logic [15:0] sig16b;
    logic        ready;
    logic        busy;
    logic        overflow;
    logic        invalid;

    int n_assert = 0;
    int n_fail   = 0;

    double_to_sig16b_serial dut (
        .clk_operation(clk_operation),
        .rst          (rst),
        .enable       (enable),
        .double       (double),
        .sig16b       (sig16b),
        .ready        (ready),
        .busy         (busy),
        .overflow     (overflow),
        .invalid      (invalid)
    );

    always #5 clk_operation = ~clk_operation;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion; e_lat < 0 skips the latency comparison.
    task automatic run(input string tag, input logic [63:0] d, input logic [15:0] e_sig,
                       input logic e_ovf, input logic e_inv, input int e_lat);
        int m;
        @(negedge clk_operation);
        double = d;
        enable = 1'b1;
        @(posedge clk_operation);
        @(negedge clk_operation);
        enable = 1'b0;
        double = ~d;
        check({tag, "_busy_start"}, busy, 1);
        m = 0;
        while (ready !== 1'b1 && m < 200) begin
            @(negedge clk_operation);
            m++;
        end
        check({tag, "_ready"}, ready, 1);
        if (e_lat >= 0) check({tag, "_latency"}, m, e_lat);
        check({tag, "_sig16b"}, sig16b, e_sig);
        check({tag, "_overflow"}, overflow, e_ovf);
        check({tag, "_invalid"}, invalid, e_inv);
        check({tag, "_busy_done"}, busy, 1);
        @(negedge clk_operation);
        check({tag, "_ready_pulse"}, ready, 0);
        check({tag, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        int          m;
        int          pulses;
        logic [15:0] v;
        int          vi;

        rst    = 1'b1;
        enable = 1'b0;
        double = 64'd0;
        repeat (3) @(negedge clk_operation);
        check("reset_sig16b", sig16b, 16'h0000);
        check("reset_ready", ready, 0);
        check("reset_busy", busy, 0);
        check("reset_overflow", overflow, 0);
        check("reset_invalid", invalid, 0);
        rst = 1'b0;

        run("d1000",    64'h408F400000000000, 16'h03E8, 1'b0, 1'b0, 45);
        run("d2p5",     64'h4004000000000000, 16'h0002, 1'b0, 1'b0, 53);
        run("dm3p5",    64'hC00C000000000000, 16'hFFFC, 1'b0, 1'b0, 53);
        run("d0p5",     64'h3FE0000000000000, 16'h0000, 1'b0, 1'b0, 55);
        run("d0p75",    64'h3FE8000000000000, 16'h0001, 1'b0, 1'b0, 55);
        run("d1p5",     64'h3FF8000000000000, 16'h0002, 1'b0, 1'b0, 54);
        run("dm0p5",    64'hBFE0000000000000, 16'h0000, 1'b0, 1'b0, 55);
        run("d40000",   64'h40E3880000000000, 16'h7FFF, 1'b1, 1'b0, 2);
        run("dm32768",  64'hC0E0000000000000, 16'h8000, 1'b0, 1'b0, 2);
        run("d32767p5", 64'h40DFFFE000000000, 16'h7FFF, 1'b1, 1'b0, 40);
        run("dm32767p5",64'hC0DFFFE000000000, 16'h8000, 1'b0, 1'b0, 40);
        run("dm40000",  64'hC0E3880000000000, 16'h8000, 1'b1, 1'b0, 2);
        run("dminf",    64'hFFF0000000000000, 16'h8000, 1'b1, 1'b0, 2);
        run("dpinf",    64'h7FF0000000000000, 16'h7FFF, 1'b1, 1'b0, 2);
        run("ddenorm",  64'h0000000000000001, 16'h0000, 1'b0, 1'b0, 2);
        run("dnan",     64'h7FF8000000000000, 16'h0000, 1'b0, 1'b1, 2);
        run("d1p0",     64'h3FF0000000000000, 16'h0001, 1'b0, 1'b0, 54);

        // Leave flags set, then abort a conversion with reset
        run("d40000b",  64'h40E3880000000000, 16'h7FFF, 1'b1, 1'b0, 2);
        @(negedge clk_operation);
        double = 64'h408F400000000000;
        enable = 1'b1;
        @(posedge clk_operation);
        @(negedge clk_operation);
        enable = 1'b0;
        repeat (10) @(negedge clk_operation);
        rst = 1'b1;
        #1;
        check("abort_sig16b", sig16b, 16'h0000);
        check("abort_busy", busy, 0);
        check("abort_overflow", overflow, 0);
        check("abort_invalid", invalid, 0);
        check("abort_ready", ready, 0);
        @(negedge clk_operation);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_operation);
            if (ready === 1'b1) pulses++;
        end
        check("abort_no_ready", pulses, 0);
        run("after_abort", 64'h4004000000000000, 16'h0002, 1'b0, 1'b0, 53);

        // Enable held high while busy; operand change must be ignored
        @(negedge clk_operation);
        double = 64'h408F400000000000;
        enable = 1'b1;
        @(posedge clk_operation);
        @(negedge clk_operation);
        m = 0;
        while (ready !== 1'b1 && m < 200) begin
            if (m == 5) double = 64'h40E3880000000000;
            @(negedge clk_operation);
            m++;
        end
        check("hold_ready", ready, 1);
        check("hold_latency", m, 45);
        check("hold_sig16b", sig16b, 16'h03E8);
        check("hold_overflow", overflow, 0);
        enable = 1'b0;
        pulses = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_operation);
            if (ready === 1'b1) pulses++;
        end
        check("hold_one_pulse", pulses, 1);

        // Round-trip: exact doubles of 16-bit integers come back unchanged
        run("rt_7fff", $realtobits(32767.0), 16'h7FFF, 1'b0, 1'b0, 40);
        run("rt_8000", $realtobits(-32768.0), 16'h8000, 1'b0, 1'b0, 2);
        run("rt_0000", $realtobits(0.0), 16'h0000, 1'b0, 1'b0, 2);
        run("rt_ffff", $realtobits(-1.0), 16'hFFFF, 1'b0, 1'b0, 54);
        for (int i = 0; i < 300; i++) begin
            v  = 16'($urandom_range(65535, 0));
            vi = $signed(v);
            run("rt_rand", $realtobits($itor(vi)), v, 1'b0, 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/double_to_sig16b_serial.md
DOUBLE_TO_SIG16B_SERIAL -- requirements
Module: double_to_sig16b_serial

Interface
REQ-001 SHALL have port clk_operation, input, 1, single operating clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port enable, input, 1, conversion request; sampled only in IDLE.
REQ-004 SHALL have port double, input, 64, IEEE-754 binary64 operand; captured on the accepting edge.
REQ-005 SHALL have port sig16b, output, 16, registered two's-complement result; holds until the next result is written.
REQ-006 SHALL have port ready, output, 1, one-cycle pulse marking sig16b valid.
REQ-007 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port overflow, output, 1, saturation flag; updated with sig16b.
REQ-009 SHALL have port invalid, output, 1, NaN-input flag; updated with sig16b.

Function
REQ-010 SHALL implement states IDLE, DECODE, SHIFT, ROUND, DONE.
REQ-011 IDLE: on an edge with enable=1, SHALL capture double and go to DECODE (edge k); enable=0 stays in IDLE.
REQ-012 SHALL ignore enable while busy; the captured operand does not change.
REQ-013 DECODE: SHALL split sign, 11-bit exponent, 52-bit fraction; unbiased e = exp-1023; mantissa = {1,fraction} (53 bits).
REQ-014 DECODE classification: NaN -> result 0, invalid=1; +/-Inf -> 0x7FFF/0x8000, overflow=1; exp=0 (zero/denormal) -> 0; e<=-2 -> 0; e>=15 -> saturate, except exactly -32768.0, which gives 0x8000 with overflow=0; each special case goes to ROUND with shift count n=0.
REQ-015 Normal range -1<=e<=14: SHALL load the shift count n=52-e (38..53) and go to SHIFT.
REQ-016 SHIFT: SHALL right-shift the mantissa one bit per edge, decrementing n and tracking guard (last bit shifted out) and sticky (OR of all earlier shifted-out bits); SHALL go to ROUND when n reaches 0.
REQ-017 ROUND: round-half-to-even; increment q when guard & (sticky | q[0]).
REQ-018 ROUND: SHALL negate q when sign=1; SHALL write sig16b, overflow, invalid; SHALL go to DONE.
REQ-019 A rounded positive magnitude of 32768 SHALL saturate to 0x7FFF with overflow=1; a negative magnitude of 32768 SHALL give 0x8000 with overflow=0.
REQ-020 Results rounding to zero SHALL output 0x0000 (no negative zero concept); a sign of 1 SHALL NOT affect a zero result.
REQ-021 DONE: ready=1 for exactly one cycle, then IDLE; a new enable SHALL be accepted on the edge leaving DONE->IDLE+1 (first IDLE cycle).
REQ-022 Latency: ready SHALL be high in the cycle after edge k+n+2 (normal: n=52-e; special: n=0, i.e. after edge k+2).
REQ-023 overflow/invalid SHALL be cleared by every non-saturating/non-NaN result.
REQ-024 The internal datapath SHALL be 53-bit mantissa shift register, 6-bit counter, 17-bit rounded magnitude; no multi-bit barrel shifter.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE; sig16b=0x0000, ready=0, busy=0, overflow=0, invalid=0; clear the counter, guard and sticky.
REQ-026 rst asserted mid-conversion SHALL abort it with no ready pulse; the first enable after rst deasserts SHALL start a fresh conversion.

Verification
REQ-027 1000.0 (0x408F400000000000) at edge k -> sig16b=0x03E8, ready high after edge k+45, busy high from k to ready.
REQ-028 2.5 (0x4004000000000000) -> 0x0002; -3.5 (0xC00C000000000000) -> 0xFFFC; 0.5 (0x3FE0000000000000) -> 0x0000; 0.75 (0x3FE8000000000000) -> 0x0001.
REQ-029 40000.0 (0x40E3880000000000) -> 0x7FFF, overflow=1; -32768.0 (0xC0E0000000000000) -> 0x8000, overflow=0; 32767.5 (0x40DFFFE000000000) -> 0x7FFF, overflow=1.
REQ-030 NaN (0x7FF8000000000000) -> 0x0000, invalid=1, ready after edge k+2; the next conversion of 1.0 -> 0x0001, invalid=0.
REQ-031 rst pulsed 10 cycles into a conversion -> all outputs are 0 and there is no ready pulse; an enable held high while busy -> exactly one ready pulse per accepted operand.
REQ-032 Round-trip: 10,000 random 16-bit values through sig16b_to_double and then this block -> the output equals the input every time (error=0), with overflow=invalid=0.
